dmem_responder: RTL

//  Memory-side responder for the core's data-memory load/store interface: a

---
 rtl/dmem_responder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM behind a valid/ready load/store
// request channel and a valid/ready response channel. It adds a programmable
// wait-state count, byte/halfword lane handling and sign/zero extension of
// loads.
//
// Optional feature: define MISALIGN_CHECK_EN to flag misaligned h/hu/w
// accesses and unsupported func3 codes as errors (rsp_err=1, no RAM write,
// rsp_rdata=0). With the macro undefined, rsp_err is always 0, w ignores
// addr[1:0] and h/hu ignore addr[0].
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   req_valid  request present; the requester holds it until accepted
//   req_ready  responder can accept (IDLE only)
//   req_we     1=store, 0=load
//   req_addr   byte address; upper bits wrap modulo the RAM size
//   req_wdata  store data, lane data in the low bits
//   req_func3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   rsp_valid  response present, held until rsp_ready
//   rsp_ready  requester takes the response
//   rsp_rdata  extended load result; 0 for stores and errors
//   rsp_err    access error (MISALIGN_CHECK_EN builds only)
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_func3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] idx;
      logic [1:0]    lane;
      logic [31:0]   wdata;
      logic [2:0]    func3;
   } acc_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt_q;
   acc_t          acc_q, req_c, acc_c;
   logic          accept_c, access_c, err_c, mem_we_c;
   logic [31:0]   word_c, byte_sh_c, load_c, rdata_n_c, wd_c;
   logic [15:0]   half_c;
   logic [3:0]    be_c;
   logic          unused_addr_c;

   logic [31:0] mem [DEPTH_WORDS];

   // Address bits above the RAM index are deliberately dropped (wrap).
   assign unused_addr_c = ^req_addr[31:2+AW];

   // Pack the incoming request.
   always_comb begin
      req_c       = '0;
      req_c.we    = req_we;
      req_c.idx   = req_addr[2 +: AW];
      req_c.lane  = req_addr[1:0];
      req_c.wdata = req_wdata;
      req_c.func3 = req_func3;
   end

   // Zero wait states access the RAM on the accept edge, before acc_q is loaded.
   assign acc_c = (state == IDLE) ? req_c : acc_q;

   // Next-state logic.
   always_comb begin
      state_n  = state;
      accept_c = 1'b0;
      access_c = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               accept_c = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_n  = RESP;
                  access_c = 1'b1;
               end else begin
                  state_n = BUSY;
               end
            end
         end
         BUSY: begin
            if (cnt_q == CW'(1)) begin
               state_n  = RESP;
               access_c = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   // Access error decode.
`ifdef MISALIGN_CHECK_EN
   always_comb begin
      case (acc_c.func3)
         3'b000, 3'b100: err_c = 1'b0;
         3'b001, 3'b101: err_c = acc_c.lane[0];
         3'b010:         err_c = (acc_c.lane != 2'b00);
         default:        err_c = 1'b1;
      endcase
   end
`else
   assign err_c = 1'b0;
`endif

   // Store lane enables and replicated write data; func3[1:0]=11 acts as w.
   always_comb begin
      be_c = 4'b1111;
      wd_c = acc_c.wdata;
      case (acc_c.func3[1:0])
         2'b00: begin
            be_c = 4'b0001 << acc_c.lane;
            wd_c = {4{acc_c.wdata[7:0]}};
         end
         2'b01: begin
            be_c = acc_c.lane[1] ? 4'b1100 : 4'b0011;
            wd_c = {2{acc_c.wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Load lane select and extension.
   always_comb begin
      word_c    = mem[acc_c.idx];
      byte_sh_c = word_c >> {acc_c.lane, 3'b000};
      half_c    = acc_c.lane[1] ? word_c[31:16] : word_c[15:0];
      case (acc_c.func3)
         3'b000:  load_c = {{24{byte_sh_c[7]}}, byte_sh_c[7:0]};
         3'b100:  load_c = {24'h0, byte_sh_c[7:0]};
         3'b001:  load_c = {{16{half_c[15]}}, half_c};
         3'b101:  load_c = {16'h0, half_c};
         default: load_c = word_c;
      endcase
      rdata_n_c = (acc_c.we || err_c) ? 32'h0 : load_c;
   end

   // No write while reset is asserted, so an abandoned store never lands.
   assign mem_we_c = access_c && acc_c.we && !err_c && rst;

   // RAM write port, byte-lane granular; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         for (int i = 0; i < 4; i++) begin
            if (be_c[i]) mem[acc_c.idx][8*i +: 8] <= wd_c[8*i +: 8];
         end
      end
   end

   // Request capture, wait counter and registered handshake outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q     <= '0;
         cnt_q     <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept_c) begin
            acc_q     <= req_c;
            cnt_q     <= CW'(WAIT_CYCLES);
            req_ready <= 1'b0;
         end else if (state == BUSY) begin
            cnt_q <= cnt_q - CW'(1);
         end
         if (access_c) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata_n_c;
            rsp_err   <= err_c;
         end
         if ((state == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
         end
      end
   end

endmodule
